// File: rtl/byte_strip.sv
// byte_strip -- transmit-side four-lane byte striper.
//
// Takes a serial byte stream (D + K flag) and deals consecutive bytes
// round-robin onto LANE0..LANE3, lane 0 taking the first byte of each group.
// A completed group is presented on all four lanes at once and is handed
// downstream through LANE_VALID/LANE_READY.
//
// Ports:
//   CLK                  single clock, rising edge
//   RESET_L              asynchronous active-low reset
//   D, DK                input byte and its K/control flag
//   IN_VALID, IN_READY   input handshake (IN_READY never looks at IN_VALID)
//   FLUSH                level request to close a partial group
//   LANE0..LANE3         striped bytes of the presented group
//   DK_0..DK_3           K flags matching LANE0..LANE3
//   LANE_VALID           lane outputs hold a complete group
//   LANE_READY           downstream consumes the group
//   FILL                 number of bytes currently staged (0..3)
//
// Build option:
//   BYTE_STRIP_PAD_EN    when defined, FLUSH emits the partial group padded
//                        with IDLE_SYM (K28.5, DK=1); when undefined, FLUSH
//                        silently discards the staged bytes.

module byte_strip #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET_L,
    input  logic [DATA_W-1:0] D,
    input  logic              DK,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic              FLUSH,
    output logic [DATA_W-1:0] LANE0,
    output logic [DATA_W-1:0] LANE1,
    output logic [DATA_W-1:0] LANE2,
    output logic [DATA_W-1:0] LANE3,
    output logic              DK_0,
    output logic              DK_1,
    output logic              DK_2,
    output logic              DK_3,
    output logic              LANE_VALID,
    input  logic              LANE_READY,
    output logic [1:0]        FILL
);

`ifdef BYTE_STRIP_PAD_EN
    localparam logic [DATA_W-1:0] IDLE_SYM = DATA_W'(8'hBC);

    // Staged lanes keep their byte; lanes beyond the fill point get K28.5.
    function automatic logic [DATA_W:0] pad_byte(input logic keep,
                                                 input logic [DATA_W-1:0] d,
                                                 input logic k);
        return keep ? {k, d} : {1'b1, IDLE_SYM};
    endfunction
`endif

    logic [1:0]        fill_p0;
    logic [DATA_W-1:0] stg_d_p0 [3];
    logic              stg_k_p0 [3];
    logic [DATA_W-1:0] lane_d_p1 [4];
    logic              lane_k_p1 [4];
    logic              vld_p1;

    logic              slot_free;
    logic              acc;
    logic              complete;
    logic [1:0]        fill_adv;
    logic [1:0]        fill_nxt;
    logic              load;
    logic [DATA_W-1:0] stg_d_n  [3];
    logic              stg_k_n  [3];
    logic [DATA_W-1:0] lane_d_n [4];
    logic              lane_k_n [4];

    assign slot_free = !vld_p1 || LANE_READY;

`ifdef BYTE_STRIP_PAD_EN
    // A flush waiting on a busy output slot also freezes the input, so the
    // partial group cannot grow while it waits.
    assign IN_READY = RESET_L &&
                      !(!slot_free && (fill_p0 == 2'd3 || (FLUSH && fill_p0 != 2'd0)));
`else
    assign IN_READY = RESET_L && !(!slot_free && fill_p0 == 2'd3);
`endif

    assign acc      = IN_VALID && IN_READY;
    assign complete = acc && (fill_p0 == 2'd3);
    assign fill_adv = acc ? fill_p0 + 2'd1 : fill_p0;

    // Staging after this edge's byte; a flush on the same edge sees it.
    always_comb begin
        stg_d_n = stg_d_p0;
        stg_k_n = stg_k_p0;
        if (acc && fill_p0 != 2'd3) begin
            stg_d_n[fill_p0] = D;
            stg_k_n[fill_p0] = DK;
        end
    end

    always_comb begin
        load     = complete;
        fill_nxt = fill_adv;
        // The lane-3 byte bypasses staging straight into the output stage.
        lane_d_n[0] = stg_d_p0[0];
        lane_d_n[1] = stg_d_p0[1];
        lane_d_n[2] = stg_d_p0[2];
        lane_d_n[3] = D;
        lane_k_n[0] = stg_k_p0[0];
        lane_k_n[1] = stg_k_p0[1];
        lane_k_n[2] = stg_k_p0[2];
        lane_k_n[3] = DK;
`ifdef BYTE_STRIP_PAD_EN
        // A completing byte leaves fill_adv at 0, so it never pads.
        if (FLUSH && fill_adv != 2'd0 && slot_free) begin
            load     = 1'b1;
            fill_nxt = 2'd0;
            {lane_k_n[0], lane_d_n[0]} = pad_byte(fill_adv > 2'd0, stg_d_n[0], stg_k_n[0]);
            {lane_k_n[1], lane_d_n[1]} = pad_byte(fill_adv > 2'd1, stg_d_n[1], stg_k_n[1]);
            {lane_k_n[2], lane_d_n[2]} = pad_byte(fill_adv > 2'd2, stg_d_n[2], stg_k_n[2]);
            lane_d_n[3] = IDLE_SYM;
            lane_k_n[3] = 1'b1;
        end
`else
        if (FLUSH && fill_adv != 2'd0) begin
            fill_nxt = 2'd0;
        end
`endif
    end

    // Stage p0: fill pointer and byte staging
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            fill_p0 <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                stg_d_p0[i] <= '0;
                stg_k_p0[i] <= 1'b0;
            end
        end else begin
            fill_p0  <= fill_nxt;
            stg_d_p0 <= stg_d_n;
            stg_k_p0 <= stg_k_n;
        end
    end

    // Stage p1: aligned four-lane output group
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            vld_p1 <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                lane_d_p1[i] <= '0;
                lane_k_p1[i] <= 1'b0;
            end
        end else begin
            if (load) begin
                vld_p1    <= 1'b1;
                lane_d_p1 <= lane_d_n;
                lane_k_p1 <= lane_k_n;
            end else if (vld_p1 && LANE_READY) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign LANE0      = lane_d_p1[0];
    assign LANE1      = lane_d_p1[1];
    assign LANE2      = lane_d_p1[2];
    assign LANE3      = lane_d_p1[3];
    assign DK_0       = lane_k_p1[0];
    assign DK_1       = lane_k_p1[1];
    assign DK_2       = lane_k_p1[2];
    assign DK_3       = lane_k_p1[3];
    assign LANE_VALID = vld_p1;
    assign FILL       = fill_p0;

endmodule

// File: doc/byte_strip.md
# byte_strip

Transmit-side byte striper for the four-lane link. It accepts a serial byte stream (8-bit data plus K/control flag) and distributes consecutive bytes round-robin across LANE0..LANE3. Lane 0 receives the first byte of each group. Each completed 4-byte group is presented on all lanes at once, aligned, through a valid/ready handshake. It sits between the framing/encoder stage and the per-lane serializers, and is the counterpart of the lane-merging block on the receive side.

## Interface
- IDLE_SYM, 8'hBC, pad symbol (K28.5) used to fill unfilled lanes on flush.
- CLK  input  1  single clock; all state on rising edge.
- RESET_L  input  1  asynchronous, active-low reset.
- D  input  8  input byte.
- DK  input  1  K/control flag accompanying D.
- IN_VALID  input  1  D/DK valid this cycle.
- IN_READY  output  1  block can accept a byte this cycle.
- FLUSH  input  1  level request to close a partial group.
- LANE0..LANE3  output  8 each  striped bytes, lane 0 = first byte of group.
- DK_0..DK_3  output  1 each  K flags matching LANE0..LANE3.
- LANE_VALID  output  1  lane outputs hold a complete group.
- LANE_READY  input  1  downstream consumes the group.
- FILL  output  2  number of bytes currently staged (0..3).

## Operation
- A byte is accepted on a rising edge with IN_VALID && IN_READY. It is written into staging slot FILL, and FILL increments modulo 4.
- Staging: 3 byte+flag registers for lanes 0..2. The lane-3 byte goes directly to the output registers together with the staged lanes 0..2.
- Output slot is "free" when !LANE_VALID || LANE_READY.
- Group completion: accepting a byte with FILL==3 loads all four lanes into the output registers, sets LANE_VALID, and sets FILL to 0. This requires a free slot.
- IN_READY = RESET_L && !(FILL==3 && !free). Combinational from FILL, LANE_VALID and LANE_READY. It never depends on IN_VALID.
- LANE_VALID clears on LANE_VALID && LANE_READY unless a new group loads on the same edge, in which case it stays high with the new data.
- Output registers and LANE_VALID are held stable while LANE_VALID && !LANE_READY.
- FLUSH behaviour: see Configuration. FLUSH with FILL==0 and no byte accepted that cycle is a no-op.
- FLUSH with a byte accepted on the same edge: the byte is staged first and FILL advances, then the flush applies to the result. If that byte completes the group, the flush is a no-op.
- Reset: FILL=0, staging cleared, LANE0..3=8'h00, DK_0..3=0, LANE_VALID=0, IN_READY=0 while RESET_L is low. Reset mid-group discards all staged bytes with no partial output.

## Timing
- Latency: lane-3 byte accepted at edge N, LANE_VALID=1 after edge N. First byte of a group reaches the lanes at minimum 3 cycles after its own acceptance.
- Sustained throughput is 1 byte/cycle with LANE_READY held high. There are no bubbles and LANE_VALID is high 1 of every 4 cycles.
- Backpressure: with LANE_READY low and an output group pending, bytes 0..2 of the next group are still accepted. IN_READY drops only at FILL==3.
- A flush takes effect on the first edge where FLUSH=1, FILL!=0 (after any same-cycle byte) and the slot is free. Until then the flush stays pending while FLUSH is held. FLUSH must be held until FILL reads 0.

## Configuration
- BYTE_STRIP_PAD_EN defined:
  - A flush emits the partial group.
  - Lanes FILL..3 are filled with IDLE_SYM and DK=1; staged lanes keep their data.
  - LANE_VALID is set and FILL becomes 0 on that edge.
  - While a flush is pending, IN_READY is 0.
- BYTE_STRIP_PAD_EN undefined:
  - FLUSH with FILL!=0 discards the staged bytes and sets FILL to 0 on the next edge, regardless of slot state.
  - No output is produced and LANE_VALID is unaffected.

## Test plan
- Reset, then stream 8'h01..8'h08 (DK=0) with LANE_READY=1 -> two groups: LANE0..3=01,02,03,04, then 05,06,07,08; LANE_VALID high one cycle each, 4 cycles apart.
- Stream 8 bytes with LANE_READY=0 -> first group held; IN_READY=0 when FILL==3. Raise LANE_READY -> second group loads on the same edge and LANE_VALID stays high.
- Feed D=8'hBC DK=1 at byte position 2 -> DK_2=1, LANE2=8'hBC, other DK_n=0.
- Feed 2 bytes (8'hA1, 8'hA2), then FLUSH=1:
  - With BYTE_STRIP_PAD_EN: lanes = A1,A2,BC,BC, DK=0,0,1,1, FILL→0.
  - Without BYTE_STRIP_PAD_EN: no LANE_VALID and FILL→0.
- Byte 3 (FILL==3) and FLUSH on the same edge -> normal complete group with no padding, FILL→0.
- Assert RESET_L=0 asynchronously with FILL==2 and LANE_VALID=1 -> all outputs 0 immediately. After release, the next 4 bytes form a fresh group starting at lane 0.
